// File: rtl/cmp_pkg.sv
// Shared encodings for the bit-serial magnitude comparator.
// Result vectors are ordered {eq, gt, lt}.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

endpackage : cmp_pkg

// File: rtl/serial_cmp_core.sv
// MSB-first serial compare core: sticky eq/gt/lt flags.
// The next-flag outputs let the sequencer capture a decision on the same edge as the last bit.
module serial_cmp_core
  import cmp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic a_bit,
  input  logic b_bit,
  output logic eq,
  output logic gt,
  output logic lt,
  output logic eq_next,
  output logic gt_next,
  output logic lt_next
);

  logic [2:0] r_flags;
  logic [2:0] w_flags_next;

  // Only the first differing bit may move the flags away from eq.
  always_comb begin
    w_flags_next = r_flags;
    if (clr) begin
      w_flags_next = R_EQ;
    end else if (en && (r_flags == R_EQ) && (a_bit != b_bit)) begin
      w_flags_next = a_bit ? R_GT : R_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= R_EQ;
    end else begin
      r_flags <= w_flags_next;
    end
  end

  assign {eq, gt, lt}                = r_flags;
  assign {eq_next, gt_next, lt_next} = w_flags_next;

endmodule : serial_cmp_core

// File: rtl/serial_compare_ctrl.sv
// Sequencer: accepts parallel operands, shifts them MSB-first through serial_cmp_core,
// and reports eq/gt/lt with a one-cycle done pulse.
module serial_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int W          = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         ready,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_sa;
  logic [W-1:0]   r_sb;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_res;

  logic w_accept;
  logic w_shift;
  logic w_a_bit;
  logic w_b_bit;
  logic w_first_diff;
  logic w_last;
  logic w_core_eq, w_core_gt, w_core_lt;
  logic w_eq_next, w_gt_next, w_lt_next;

  assign w_shift      = (r_state == S_SHIFT);
  assign w_a_bit      = r_sa[W-1];
  assign w_b_bit      = r_sb[W-1];
  assign w_first_diff = w_shift && ({w_core_eq, w_core_gt, w_core_lt} == R_EQ) && (w_a_bit != w_b_bit);
  assign w_last       = w_shift && ((r_cnt == '0) || (EARLY_EXIT && w_first_diff));

  serial_cmp_core u_core (
    .clk     (clk),
    .reset   (reset),
    .clr     (w_accept),
    .en      (w_shift),
    .a_bit   (w_a_bit),
    .b_bit   (w_b_bit),
    .eq      (w_core_eq),
    .gt      (w_core_gt),
    .lt      (w_core_lt),
    .eq_next (w_eq_next),
    .gt_next (w_gt_next),
    .lt_next (w_lt_next)
  );

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_sa  <= a_in;
        r_sb  <= b_in;
        r_cnt <= CW'(W - 1);
        r_res <= '0;
      end else if (w_shift) begin
        r_sa <= r_sa << 1;
        r_sb <= r_sb << 1;
        // Hold at zero on the exit edge so the counter never wraps.
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (w_last) r_res <= {w_eq_next, w_gt_next, w_lt_next};
      end
    end
  end

  assign {eq, gt, lt} = r_res;

endmodule : serial_compare_ctrl

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (W=4): one full-length and one early-exit instance
// share the stimulus; each expected value below is worked out by hand from the operands.
module tb_serial_compare_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;

  logic f_ready, f_done, f_eq, f_gt, f_lt;
  logic e_ready, e_done, e_eq, e_gt, e_lt;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.W(W), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .ready(f_ready), .done(f_done), .eq(f_eq), .gt(f_gt), .lt(f_lt)
  );

  serial_compare_ctrl #(.W(W), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .ready(e_ready), .done(e_done), .eq(e_eq), .gt(e_gt), .lt(e_lt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance past one rising edge; outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", {31'd0, f_ready}, 32'd1);
    chk("rst_done",  {31'd0, f_done}, 32'd0);
    chk("rst_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b000);
    chk("rst_e_flags", {29'd0, e_eq, e_gt, e_lt}, 32'b000);

    // 1: 0110 vs 1100 -> lt
    launch(4'b0110, 4'b1100);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t1_nodone_e%0d", k), {31'd0, f_done}, 32'd0);
    end
    tick();
    chk("t1_done",  {31'd0, f_done}, 32'd1);
    chk("t1_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b001);
    chk("t1_busy",  {31'd0, f_ready}, 32'd0);
    tick();
    chk("t1_ready", {31'd0, f_ready}, 32'd1);
    chk("t1_done_low", {31'd0, f_done}, 32'd0);

    // 2: 1010 vs 1010 -> eq, held while idle
    launch(4'b1010, 4'b1010);
    tick(); tick(); tick(); tick();
    chk("t2_done",  {31'd0, f_done}, 32'd1);
    chk("t2_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b100);
    for (int k = 0; k < 10; k++) tick();
    chk("t2_hold_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b100);
    chk("t2_hold_done",  {31'd0, f_done}, 32'd0);

    // 3: 1000 vs 0111 -> gt; early exit after edge 1, full after edge 4
    launch(4'b1000, 4'b0111);
    chk("t3_e_busy", {31'd0, e_ready}, 32'd0);
    tick();
    chk("t3_e_done",  {31'd0, e_done}, 32'd1);
    chk("t3_e_flags", {29'd0, e_eq, e_gt, e_lt}, 32'b010);
    chk("t3_f_nodone", {31'd0, f_done}, 32'd0);
    tick();
    chk("t3_e_done_low", {31'd0, e_done}, 32'd0);
    chk("t3_e_ready", {31'd0, e_ready}, 32'd1);
    tick(); tick();
    chk("t3_f_done",  {31'd0, f_done}, 32'd1);
    chk("t3_f_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b010);
    tick();

    // 4: 0011 vs 0010 accepted; a second start while busy is ignored
    launch(4'b0011, 4'b0010);
    tick();
    start = 1'b1; a_in = 4'b1111; b_in = 4'b0000;
    tick();
    chk("t4_busy", {31'd0, f_ready}, 32'd0);
    start = 1'b0;
    chk("t4_nodone", {31'd0, f_done}, 32'd0);
    tick(); tick();
    chk("t4_done",  {31'd0, f_done}, 32'd1);
    chk("t4_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b010);
    chk("t4_e_flags", {29'd0, e_eq, e_gt, e_lt}, 32'b010);
    tick();
    chk("t4_ready", {31'd0, f_ready}, 32'd1);

    // 5: reset at edge 2 aborts the op
    launch(4'b0100, 4'b0010);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_ready", {31'd0, f_ready}, 32'd1);
    chk("t5_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b000);
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      if (f_done) n_done++;
      tick();
    end
    chk("t5_no_done", n_done, 32'd0);
    launch(4'b0001, 4'b0001);
    tick(); tick(); tick(); tick();
    chk("t5_after_done",  {31'd0, f_done}, 32'd1);
    chk("t5_after_flags", {29'd0, f_eq, f_gt, f_lt}, 32'b100);
    tick();

    // 6: start held -> accepts at edges 0 and 6
    start = 1'b1; a_in = 4'b0101; b_in = 4'b0101;
    tick();
    n_done = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) begin a_in = 4'b0001; b_in = 4'b0100; end
      if (k == 7) start = 1'b0;
      if (f_done) n_done++;
      if (k == 4) begin
        chk("t6_done1",  {31'd0, f_done}, 32'd1);
        chk("t6_flags1", {29'd0, f_eq, f_gt, f_lt}, 32'b100);
      end
      if (k == 5)  chk("t6_idle", {31'd0, f_ready}, 32'd1);
      if (k == 6)  chk("t6_reaccept", {31'd0, f_ready}, 32'd0);
      if (k == 10) begin
        chk("t6_done2",  {31'd0, f_done}, 32'd1);
        chk("t6_flags2", {29'd0, f_eq, f_gt, f_lt}, 32'b001);
      end
    end
    chk("t6_done_count", n_done, 32'd2);
    chk("t6_final_ready", {31'd0, f_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_serial_compare_ctrl
